wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and the long-latency M-extension divider. Divider results are buffered in a small FIFO and drained into idle writeback slots. If a result waits too long, or the FIFO fills, the pipeline writeback is stalled for one cycle. A 32-bit scoreboard of registers with outstanding divider results is kept for the hazard unit.

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between writeback and the divider FIFO.
// Optional same-cycle divider bypass: define WB_PORT_ARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        DivIssue,
  input  logic [4:0]  DivIssueRd,
  input  logic        DivValid,
  input  logic [4:0]  DivRd,
  input  logic [31:0] DivResult,
  output logic        DivReady,
  output logic        StallW,
  output logic [31:0] BusyMask,
  output logic        RegWriteOut,
  output logic [4:0]  RdOut,
  output logic [31:0] WDOut
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]    fifoRd   [DEPTH];
  logic [31:0]   fifoData [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic [3:0]    waitCnt;
  logic [3:0]    waitNext;
  logic [31:0]   busyQ;
  logic [31:0]   busyNext;
  logic [31:0]   setMask;
  logic [31:0]   clrMask;

  logic        pipeReq;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        forceDrain;
  logic [4:0]  headRd;
  logic [31:0] headData;

  assign pipeReq    = RegWriteW && (RdW != 5'd0);
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign DivReady   = !full;
  assign headRd     = fifoRd[rdPtr];
  assign headData   = fifoData[rdPtr];
  assign forceDrain = (waitCnt == 4'(MAX_WAIT)) || full;

`ifdef WB_PORT_ARB_BYPASS_EN
  assign bypass = empty && !pipeReq && DivValid
               && (DivRd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results are acknowledged but never stored
  assign push = DivValid && !full
             && (DivRd != 5'd0) && !bypass;

  always_comb begin
    pop         = 1'b0;
    StallW      = 1'b0;
    RegWriteOut = 1'b0;
    RdOut       = 5'd0;
    WDOut       = 32'd0;
    waitNext    = waitCnt;
    unique case (1'b1)
      empty: begin
        waitNext = 4'd0;
        if (bypass) begin
          RegWriteOut = 1'b1;
          RdOut       = DivRd;
          WDOut       = DivResult;
        end else if (pipeReq) begin
          RegWriteOut = 1'b1;
          RdOut       = RdW;
          WDOut       = ResultW;
        end
      end
      (!empty && !pipeReq): begin
        pop         = 1'b1;
        RegWriteOut = 1'b1;
        RdOut       = headRd;
        WDOut       = headData;
        waitNext    = 4'd0;
      end
      (!empty && pipeReq && forceDrain): begin
        pop         = 1'b1;
        StallW      = 1'b1;
        RegWriteOut = 1'b1;
        RdOut       = headRd;
        WDOut       = headData;
        waitNext    = 4'd0;
      end
      (!empty && pipeReq && !forceDrain): begin
        RegWriteOut = 1'b1;
        RdOut       = RdW;
        WDOut       = ResultW;
        waitNext    = waitCnt + 4'd1;
      end
      default: begin
        waitNext = waitCnt;
      end
    endcase
  end

  always_comb begin
    countNext = count;
    unique case ({push, pop})
      2'b10:   countNext = count + CW'(1);
      2'b01:   countNext = count - CW'(1);
      default: countNext = count;
    endcase
  end

  // set beats clear on the same bit
  always_comb begin
    setMask = 32'd0;
    clrMask = 32'd0;
    if (DivIssue && (DivIssueRd != 5'd0))
      setMask = 32'd1 << DivIssueRd;
    if (pop)
      clrMask = clrMask | (32'd1 << headRd);
    if (bypass)
      clrMask = clrMask | (32'd1 << DivRd);
    busyNext = ((busyQ & ~clrMask) | setMask)
             & ~32'd1;
  end

  assign BusyMask = busyQ;

  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= DivRd;
      fifoData[wrPtr] <= DivResult;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      waitCnt <= 4'd0;
      busyQ   <= 32'd0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PW'(1);
      if (pop)
        rdPtr <= rdPtr + PW'(1);
      count   <= countNext;
      waitCnt <= waitNext;
      busyQ   <= busyNext;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-cycle expected port state
// is queued by the stimulus and checked by a negedge monitor.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic        DivIssue = 1'b0;
  logic [4:0]  DivIssueRd = '0;
  logic        DivValid = 1'b0;
  logic [4:0]  DivRd = '0;
  logic [31:0] DivResult = '0;
  logic        DivReady;
  logic        StallW;
  logic [31:0] BusyMask;
  logic        RegWriteOut;
  logic [4:0]  RdOut;
  logic [31:0] WDOut;

  wb_port_arbiter #(
    .DEPTH(2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RegWriteW(RegWriteW),
    .RdW(RdW),
    .ResultW(ResultW),
    .DivIssue(DivIssue),
    .DivIssueRd(DivIssueRd),
    .DivValid(DivValid),
    .DivRd(DivRd),
    .DivResult(DivResult),
    .DivReady(DivReady),
    .StallW(StallW),
    .BusyMask(BusyMask),
    .RegWriteOut(RegWriteOut),
    .RdOut(RdOut),
    .WDOut(WDOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned id;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        st;
    logic        rdy;
    logic [31:0] bm;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned seq = 0;
  logic        done = 1'b0;

  task automatic setIn(
    input logic rw, input logic [4:0] rdw,
    input logic [31:0] resw,
    input logic di, input logic [4:0] dird,
    input logic dv, input logic [4:0] drd,
    input logic [31:0] dres);
    RegWriteW  = rw;
    RdW        = rdw;
    ResultW    = resw;
    DivIssue   = di;
    DivIssueRd = dird;
    DivValid   = dv;
    DivRd      = drd;
    DivResult  = dres;
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(
    input logic we, input logic [4:0] rd,
    input logic [31:0] wd, input logic st,
    input logic rdy, input logic [31:0] bm);
    exp_t e;
    e.id  = seq;
    e.we  = we;
    e.rd  = rd;
    e.wd  = wd;
    e.st  = st;
    e.rdy = rdy;
    e.bm  = bm;
    seq++;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (RegWriteOut !== e.we || RdOut !== e.rd
          || WDOut !== e.wd || StallW !== e.st
          || DivReady !== e.rdy || BusyMask !== e.bm) begin
        failures++;
        $display("FAIL step%0d port: got we=%0b rd=%0d wd=%h st=%0b rdy=%0b busy=%h want we=%0b rd=%0d wd=%h st=%0b rdy=%0b busy=%h",
                 e.id, RegWriteOut, RdOut, WDOut, StallW,
                 DivReady, BusyMask, e.we, e.rd, e.wd,
                 e.st, e.rdy, e.bm);
      end
    end else if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    setIn(0, 0, 0, 0, 0, 1, 7, 32'hdead);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (DivReady !== 1'b1) begin
      failures++;
      $display("FAIL reset: DivReady=%0b", DivReady);
    end
    checks++;
    if (BusyMask !== 32'd0) begin
      failures++;
      $display("FAIL reset: BusyMask=%h", BusyMask);
    end
    checks++;
    if (RegWriteOut !== 1'b0) begin
      failures++;
      $display("FAIL reset: RegWriteOut=%0b", RegWriteOut);
    end
    checks++;
    if (StallW !== 1'b0) begin
      failures++;
      $display("FAIL reset: StallW=%0b", StallW);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    setIn(0, 0, 0, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    setIn(0, 0, 0, 0, 0, 1, 5, 7);
`ifdef WB_PORT_ARB_BYPASS_EN
    cyc(1, 5, 7, 0, 1, 32'h20);
    idle();
    cyc(0, 0, 0, 0, 1, 0);
`else
    cyc(0, 0, 0, 0, 1, 32'h20);
    idle();
    cyc(1, 5, 7, 0, 1, 32'h20);
`endif
    cyc(0, 0, 0, 0, 1, 0);

    setIn(1, 0, 32'h55, 1, 0, 1, 0, 32'h99);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 0);

    setIn(0, 0, 0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    setIn(1, 3, 32'h31, 0, 0, 1, 9, 32'h1234);
    cyc(1, 3, 32'h31, 0, 1, 32'h200);
    setIn(1, 3, 32'h32, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h32, 0, 1, 32'h200);
    setIn(1, 3, 32'h33, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h33, 0, 1, 32'h200);
    setIn(1, 3, 32'h34, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h34, 0, 1, 32'h200);
    setIn(1, 3, 32'h35, 0, 0, 0, 0, 0);
    cyc(1, 3, 32'h35, 0, 1, 32'h200);
    setIn(1, 3, 32'h36, 0, 0, 0, 0, 0);
    cyc(1, 9, 32'h1234, 1, 1, 32'h200);
    cyc(1, 3, 32'h36, 0, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 1, 0);

    setIn(0, 0, 0, 1, 10, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    setIn(0, 0, 0, 1, 11, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h400);
    setIn(1, 4, 32'h44, 0, 0, 1, 10, 32'hA0);
    cyc(1, 4, 32'h44, 0, 1, 32'hC00);
    setIn(1, 4, 32'h45, 0, 0, 1, 11, 32'hB0);
    cyc(1, 4, 32'h45, 0, 1, 32'hC00);
    setIn(1, 6, 32'h66, 0, 0, 1, 12, 32'hC0);
    cyc(1, 10, 32'hA0, 1, 0, 32'hC00);
    cyc(1, 6, 32'h66, 0, 1, 32'h800);
    idle();
    cyc(1, 11, 32'hB0, 0, 0, 32'h800);
    cyc(1, 12, 32'hC0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    setIn(0, 0, 0, 1, 10, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    setIn(0, 0, 0, 1, 11, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h400);
    setIn(1, 4, 32'h44, 0, 0, 1, 10, 32'hA0);
    cyc(1, 4, 32'h44, 0, 1, 32'hC00);
    setIn(1, 4, 32'h45, 0, 0, 1, 11, 32'hB0);
    cyc(1, 4, 32'h45, 0, 1, 32'hC00);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (BusyMask !== 32'd0) begin
      failures++;
      $display("FAIL midreset: BusyMask=%h", BusyMask);
    end
    checks++;
    if (RegWriteOut !== 1'b0) begin
      failures++;
      $display("FAIL midreset: RegWriteOut=%0b", RegWriteOut);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    done = 1'b1;
  end

endmodule
